// File: rtl/vga_pkg.sv
// Constants and types shared by the blocks on the cpu_clk side of the 512x512
// RGB332 image RAM (fill engine, vga_ctrl).
package vga_pkg;

    localparam int IMG_W         = 512;
    localparam int IMG_H         = 512;
    localparam int WORDS_PER_ROW = IMG_W / 8;
    localparam int COL_W         = $clog2(WORDS_PER_ROW);
    localparam int ADDR_W        = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_e;

    localparam int RGB_R_HI = 7;
    localparam int RGB_R_LO = 5;
    localparam int RGB_G_HI = 4;
    localparam int RGB_G_LO = 2;
    localparam int RGB_B_HI = 1;
    localparam int RGB_B_LO = 0;

endpackage

// File: rtl/vga_lane_mask.sv
// Byte-lane write enables for one 8-pixel word; lane 0 is the leftmost pixel.
module vga_lane_mask (
    input  logic [2:0] start_off_i,
    input  logic [2:0] end_off_i,
    input  logic       first_i,
    input  logic       last_i,
    output logic [7:0] wen_o
);

    logic [7:0] head_mask;
    logic [7:0] tail_mask;

    always_comb begin
        head_mask = 8'hFF << start_off_i;
        tail_mask = 8'hFF >> (3'd7 - end_off_i);
        wen_o     = 8'hFF;
        if (first_i) wen_o = wen_o & head_mask;
        if (last_i)  wen_o = wen_o & tail_mask;
    end

endmodule

// File: rtl/vga_fill_engine.sv
// Rectangle fill into the image RAM, one masked 64-bit word per cycle; CPU
// accesses share the RAM port and always win arbitration.
//
// state   | meaning
// IDLE    | ready for a command; bad commands pulse err_o
// FILL    | issuing words row by row, stalled while cpu_en=1
// DONE    | one-cycle done_o pulse, not ready
module vga_fill_engine
    import vga_pkg::*;
(
    input  logic              cpu_clk,
    input  logic              rst_n_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [8:0]        cmd_x,
    input  logic [8:0]        cmd_y,
    input  logic [9:0]        cmd_w,
    input  logic [9:0]        cmd_h,
    input  logic [7:0]        cmd_color,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    input  logic              cpu_en,
    input  logic [7:0]        cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [63:0]       cpu_wdata,
    output logic [63:0]       cpu_rdata,
    output logic              ram_en,
    output logic [7:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [63:0]       ram_wdata,
    input  logic [63:0]       ram_rdata
);

    fill_state_e       state_q, state_d;
    logic [7:0]        color_q, color_d;
    logic [COL_W-1:0]  first_col_q, first_col_d;
    logic [COL_W-1:0]  last_col_q, last_col_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [2:0]        start_off_q, start_off_d;
    logic [2:0]        end_off_q, end_off_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [9:0]        rows_left_q, rows_left_d;
    logic              err_q, err_d;

    logic [10:0] x_sum, y_sum;
    logic [8:0]  x_last;
    logic        cmd_ok;
    logic        issue;
    logic [7:0]  lane_wen;

    // 11-bit sums keep the bounds check free of wrap-around
    assign x_sum  = {2'b00, cmd_x} + {1'b0, cmd_w};
    assign y_sum  = {2'b00, cmd_y} + {1'b0, cmd_h};
    assign x_last = cmd_x + cmd_w[8:0] - 9'd1;
    assign cmd_ok = (cmd_w != 10'd0) && (cmd_h != 10'd0) &&
                    (x_sum <= 11'(IMG_W)) && (y_sum <= 11'(IMG_H));
    assign issue  = (state_q == ST_FILL) && !cpu_en;

    vga_lane_mask u_lane_mask (
        .start_off_i (start_off_q),
        .end_off_i   (end_off_q),
        .first_i     (col_q == first_col_q),
        .last_i      (col_q == last_col_q),
        .wen_o       (lane_wen)
    );

    always_ff @(posedge cpu_clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            color_q     <= '0;
            first_col_q <= '0;
            last_col_q  <= '0;
            col_q       <= '0;
            start_off_q <= '0;
            end_off_q   <= '0;
            row_base_q  <= '0;
            rows_left_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            color_q     <= color_d;
            first_col_q <= first_col_d;
            last_col_q  <= last_col_d;
            col_q       <= col_d;
            start_off_q <= start_off_d;
            end_off_q   <= end_off_d;
            row_base_q  <= row_base_d;
            rows_left_q <= rows_left_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        color_d     = color_q;
        first_col_d = first_col_q;
        last_col_d  = last_col_q;
        col_d       = col_q;
        start_off_d = start_off_q;
        end_off_d   = end_off_q;
        row_base_d  = row_base_q;
        rows_left_d = rows_left_q;
        err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_ok) begin
                        state_d     = ST_FILL;
                        color_d     = cmd_color;
                        first_col_d = cmd_x[8:3];
                        last_col_d  = x_last[8:3];
                        col_d       = cmd_x[8:3];
                        start_off_d = cmd_x[2:0];
                        end_off_d   = x_last[2:0];
                        row_base_d  = {cmd_y, {COL_W{1'b0}}};
                        rows_left_d = cmd_h;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                if (issue) begin
                    if (col_q == last_col_q) begin
                        // rows_left counts down to a terminal value of 1
                        if (rows_left_q == 10'd1) begin
                            state_d = ST_DONE;
                        end else begin
                            col_d       = first_col_q;
                            row_base_d  = row_base_q + ADDR_W'(WORDS_PER_ROW);
                            rows_left_d = rows_left_q - 10'd1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy_o    = (state_q == ST_FILL);
    assign done_o    = (state_q == ST_DONE);
    assign err_o     = err_q;
    assign cpu_rdata = ram_rdata;

    always_comb begin
        ram_en    = 1'b0;
        ram_wen   = 8'h00;
        ram_addr  = '0;
        ram_wdata = '0;
        if (cpu_en) begin
            ram_en    = 1'b1;
            ram_wen   = cpu_wen;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end else if (state_q == ST_FILL) begin
            ram_en    = 1'b1;
            ram_wen   = lane_wen;
            ram_addr  = row_base_q + ADDR_W'(col_q);
            ram_wdata = {8{color_q}};
        end
    end

endmodule

// File: tb/tb_vga_fill_engine.sv
// Bench for vga_fill_engine: directed and random fills against a pixel-level
// reference image, with an attached RAM model for CPU read-back.
module tb_vga_fill_engine;

    logic        cpu_clk = 1'b0;
    logic        rst_n_i;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [8:0]  cmd_x, cmd_y;
    logic [9:0]  cmd_w, cmd_h;
    logic [7:0]  cmd_color;
    logic        busy_o, done_o, err_o;
    logic        cpu_en;
    logic [7:0]  cpu_wen;
    logic [14:0] cpu_addr;
    logic [63:0] cpu_wdata, cpu_rdata;
    logic        ram_en;
    logic [7:0]  ram_wen;
    logic [14:0] ram_addr;
    logic [63:0] ram_wdata;
    logic [63:0] ram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] mem [0:32767];
    logic        mem_init;
    logic [7:0]  ref_img [0:262143];

    int          obs_addr[$];
    logic [7:0]  obs_wen[$];
    logic [63:0] obs_wdata[$];

    always #5 cpu_clk = ~cpu_clk;

    vga_fill_engine dut (
        .cpu_clk   (cpu_clk),
        .rst_n_i   (rst_n_i),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .cpu_en    (cpu_en),
        .cpu_wen   (cpu_wen),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .ram_en    (ram_en),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // image RAM port A: byte-masked write, read-first, 1-cycle read latency
    always @(posedge cpu_clk) begin
        if (mem_init !== 1'b1) begin
            for (int i = 0; i < 32768; i++) mem[i] <= 64'd0;
            mem_init  <= 1'b1;
            ram_rdata <= 64'd0;
        end else if (ram_en) begin
            ram_rdata <= mem[ram_addr];
            for (int i = 0; i < 8; i++)
                if (ram_wen[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_word(input int a);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = ref_img[(a / 64) * 512 + 8 * (a % 64) + i];
        return w;
    endfunction

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    // s_fix=0 picks a random stall start inside the fill
    task automatic run_fill(input int x, input int y, input int w, input int h,
                            input logic [7:0] col, input int s_fix, input int slen_req,
                            input bit stall_wr, input string tag);
        int          exp_addr[$];
        logic [7:0]  exp_wen[$];
        logic [7:0]  m;
        int n, s, slen, nwr, nbad, cpu_bad, flag_bad, done_at;
        for (int r = y; r < y + h; r++)
            for (int c = x / 8; c <= (x + w - 1) / 8; c++) begin
                m = 8'h00;
                for (int i = 0; i < 8; i++)
                    if (8 * c + i >= x && 8 * c + i < x + w) m[i] = 1'b1;
                exp_addr.push_back(r * 64 + c);
                exp_wen.push_back(m);
            end
        for (int r = y; r < y + h; r++)
            for (int p = x; p < x + w; p++) ref_img[r * 512 + p] = col;
        n    = exp_addr.size();
        slen = (n < 2) ? 0 : slen_req;
        s    = (s_fix != 0) ? s_fix : ((n < 2) ? 2 : int'($urandom_range(2, n)));
        obs_addr.delete(); obs_wen.delete(); obs_wdata.delete();
        nwr = 0; nbad = 0; cpu_bad = 0; flag_bad = 0; done_at = 0;
        cmd_x = 9'(x); cmd_y = 9'(y); cmd_w = 10'(w); cmd_h = 10'(h); cmd_color = col;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 1; i <= n + slen + 8 && done_at == 0; i++) begin
            if (cpu_en) begin
                if (!ram_en || ram_addr !== cpu_addr || ram_wen !== cpu_wen ||
                    ram_wdata !== cpu_wdata) cpu_bad++;
            end else if (ram_en) begin
                obs_addr.push_back(int'(ram_addr));
                obs_wen.push_back(ram_wen);
                obs_wdata.push_back(ram_wdata);
                if (nwr >= n || int'(ram_addr) != exp_addr[nwr] || ram_wen !== exp_wen[nwr] ||
                    ram_wdata !== {8{col}}) nbad++;
                nwr++;
            end
            if (done_o) begin
                done_at = i;
                if (busy_o || ram_en) flag_bad++;
            end else if (!busy_o) flag_bad++;
            if (cmd_ready) flag_bad++;
            cpu_en    = (i + 1 >= s) && (i + 1 < s + slen);
            cpu_wen   = stall_wr ? 8'hFF : 8'h00;
            cpu_addr  = stall_wr ? 15'h7FFF : 15'($urandom);
            cpu_wdata = {$urandom, $urandom};
            if (cpu_en && stall_wr)
                for (int k = 0; k < 8; k++) ref_img[511 * 512 + 504 + k] = cpu_wdata[8*k +: 8];
            tick();
        end
        cpu_en = 1'b0;
        check({tag, "_nwords"}, 64'(nwr), 64'(n));
        check({tag, "_bad_words"}, 64'(nbad), 64'd0);
        check({tag, "_done_cycle"}, 64'(done_at), 64'(n + slen + 1));
        check({tag, "_flags"}, 64'(flag_bad), 64'd0);
        if (slen > 0) check({tag, "_cpu_mux"}, 64'(cpu_bad), 64'd0);
        check({tag, "_after_done"}, {61'd0, done_o, cmd_ready, ram_en}, 64'b010);
    endtask

    task automatic run_reject(input int x, input int y, input int w, input int h, input string tag);
        int bad;
        cmd_x = 9'(x); cmd_y = 9'(y); cmd_w = 10'(w); cmd_h = 10'(h); cmd_color = 8'h5A;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check({tag, "_err"}, {61'd0, err_o, cmd_ready, ram_en}, 64'b110);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (err_o || ram_en || !cmd_ready || busy_o) bad++;
        end
        check({tag, "_quiet"}, 64'(bad), 64'd0);
    endtask

    task automatic cpu_read_check(input int a, input string tag);
        cpu_en = 1'b1; cpu_wen = 8'h00; cpu_addr = 15'(a);
        tick();
        cpu_en = 1'b0;
        check(tag, cpu_rdata, ref_word(a));
    endtask

    initial begin
        int x, y, w, h, bad;
        for (int i = 0; i < 262144; i++) ref_img[i] = 8'h00;
        rst_n_i = 1'b0; cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0;
        cmd_color = '0; cpu_en = 1'b1; cpu_wen = 8'h00; cpu_addr = 15'h1234; cpu_wdata = '0;
        #2;
        check("reset_flags", {60'd0, cmd_ready, busy_o, done_o, err_o}, 64'b1000);
        check("reset_cpu_pass", {48'd0, ram_en, ram_addr}, {48'd0, 1'b1, 15'h1234});
        cpu_en = 1'b0;
        #1;
        check("reset_ram_idle", {55'd0, ram_en, ram_wen}, 64'd0);
        tick(); tick();
        rst_n_i = 1'b1;
        tick();

        run_fill(3, 0, 2, 1, 8'hE0, 0, 0, 1'b0, "single");
        check("single_addr", 64'(obs_addr[0]), 64'd0);
        check("single_wen", 64'(obs_wen[0]), 64'h18);
        check("single_wdata", obs_wdata[0], 64'hE0E0E0E0E0E0E0E0);

        run_fill(6, 1, 12, 1, 8'h1C, 0, 0, 1'b0, "three");
        check("three_addrs", {16'd0, 16'(obs_addr[0]), 16'(obs_addr[1]), 16'(obs_addr[2])},
              {16'd0, 16'd64, 16'd65, 16'd66});
        check("three_wens", {40'd0, obs_wen[0], obs_wen[1], obs_wen[2]}, 64'hC0FF03);

        run_reject(500, 0, 20, 1, "rej_xw");
        run_reject(0, 0, 0, 1, "rej_w0");
        run_reject(0, 510, 8, 3, "rej_yh");
        run_reject(0, 0, 8, 0, "rej_h0");

        run_fill(0, 2, 64, 2, 8'h3C, 5, 3, 1'b1, "stall");
        cpu_read_check(32767, "stall_cpu_word");

        for (int t = 0; t < 10; t++) begin
            x = int'($urandom_range(0, 511));
            w = int'($urandom_range(1, 512 - x));
            h = int'($urandom_range(1, 6));
            y = int'($urandom_range(0, 512 - h));
            run_fill(x, y, w, h, 8'($urandom), 0, int'($urandom_range(0, 3)), 1'b0, "rand");
            cpu_read_check(y * 64 + x / 8, "rand_rb_first");
            cpu_read_check((y + h - 1) * 64 + (x + w - 1) / 8, "rand_rb_last");
        end
        for (int t = 0; t < 3; t++) begin
            x = int'($urandom_range(1, 511));
            run_reject(x, 0, 513 - x + int'($urandom_range(0, 10)), 1, "rand_rej");
        end
        cpu_read_check(64, "rb_three");

        // abandon a fill with reset, then confirm the engine recovers
        cmd_x = 9'd0; cmd_y = 9'd8; cmd_w = 10'd512; cmd_h = 10'd8; cmd_color = 8'h77;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("pre_reset_busy", {63'd0, busy_o}, 64'd1);
        rst_n_i = 1'b0;
        #1;
        check("async_reset", {59'd0, cmd_ready, busy_o, done_o, err_o, ram_en}, 64'b10000);
        tick();
        rst_n_i = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done_o || ram_en || busy_o) bad++;
        end
        check("post_reset_quiet", 64'(bad), 64'd0);
        run_fill(10, 20, 30, 2, 8'hA5, 0, 1, 1'b0, "after_rst");
        cpu_read_check(20 * 64 + 1, "after_rst_rb");

        run_fill(0, 0, 512, 512, 8'hFF, 0, 0, 1'b0, "full");
        check("full_first_addr", 64'(obs_addr[0]), 64'd0);
        check("full_last_addr", 64'(obs_addr[obs_addr.size() - 1]), 64'd32767);
        cpu_read_check(0, "full_rb_0");
        cpu_read_check(32767, "full_rb_end");
        for (int t = 0; t < 6; t++) cpu_read_check(int'($urandom_range(0, 32767)), "full_rb_rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
